// File: rtl/tone_sequencer.sv
// Note-table player: walks a writable table of {dur, note} entries and emits key press/release codes.
// Prescaled duration ticks, loop/stop control and a busy/done handshake toward the alarm controller.
//   state | meaning
//   IDLE  | silent, waiting for start
//   LOAD  | fetch table[step_idx], skip if duration decodes to zero
//   PLAY  | note sounding for D ticks
//   GAP   | release code for GAP_T ticks
//   NEXT  | advance step, wrap in loop mode, or finish
module tone_sequencer #(
  parameter int         DEPTH    = 16,
  parameter int         TICK_DIV = 50000,
  parameter int         GAP_T    = 2,
  parameter logic [7:0] KEY_REL  = 8'hF0,
  localparam int        AW       = $clog2(DEPTH),
  localparam int        LW       = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          k_tr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          loop,
  input  logic          stop,
  output logic [7:0]    key_code,
  output logic [AW-1:0] step_idx,
  output logic          busy,
  output logic          done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_NEXT} state_t;

  state_t          state, state_nx;
  logic [7:0]      mem [DEPTH];
  logic [3:0]      note_lat;
  logic [8:0]      tcnt;
  logic [PW-1:0]   pre;
  logic [LW-1:0]   len_lat;
  logic            loop_lat;
  logic            tick;
  logic            last;
  logic [8:0]      load_dur;

  function automatic logic [7:0] note_dec(input logic [3:0] n);
    case (n)
      4'd1:    note_dec = 8'h2B;
      4'd2:    note_dec = 8'h34;
      4'd3:    note_dec = 8'h33;
      4'd4:    note_dec = 8'h3B;
      4'd5:    note_dec = 8'h42;
      4'd6:    note_dec = 8'h4B;
      4'd7:    note_dec = 8'h4C;
      4'd10:   note_dec = 8'h52;
      default: note_dec = KEY_REL;
    endcase
  endfunction

  function automatic logic [8:0] dur_dec(input logic [3:0] d);
    case (d)
      4'd15:   dur_dec = 9'd16;
      4'd8:    dur_dec = 9'd32;
      4'd9:    dur_dec = 9'd48;
      4'd1:    dur_dec = 9'd64;
      4'd3:    dur_dec = 9'd96;
      4'd2:    dur_dec = 9'd128;
      4'd4:    dur_dec = 9'd256;
      default: dur_dec = 9'd0;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    tick     = ((state == S_PLAY) || (state == S_GAP)) && (pre == PW'(TICK_DIV - 1));
    last     = (LW'(step_idx) == (len_lat - LW'(1)));
    load_dur = dur_dec(mem[step_idx][7:4]);
    key_code = KEY_REL;
    case (state)
      S_IDLE: if (start && (len != '0) && !stop) state_nx = S_LOAD;
      S_LOAD: state_nx = (load_dur == 9'd0) ? S_NEXT : S_PLAY;
      S_PLAY: begin
        key_code = note_dec(note_lat);
        if (tick && (tcnt == 9'd1)) state_nx = S_GAP;
      end
      S_GAP:  if (tick && (tcnt == 9'd1)) state_nx = S_NEXT;
      S_NEXT: state_nx = (last && !loop_lat) ? S_IDLE : S_LOAD;
      default: state_nx = S_IDLE;
    endcase
    if ((state != S_IDLE) && stop) state_nx = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (!k_tr) begin
      state    <= S_IDLE;
      step_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      note_lat <= '0;
      tcnt     <= '0;
      pre      <= '0;
      len_lat  <= '0;
      loop_lat <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      if (wr_en) mem[wr_addr] <= wr_data;
      case (state)
        S_IDLE: if (state_nx == S_LOAD) begin
          step_idx <= '0;
          busy     <= 1'b1;
          len_lat  <= (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
          loop_lat <= loop;
        end
        S_LOAD: begin
          note_lat <= mem[step_idx][3:0];
          tcnt     <= load_dur;
          pre      <= '0;
        end
        S_PLAY, S_GAP: begin
          pre <= tick ? '0 : pre + PW'(1);
          if (tick) tcnt <= tcnt - 9'd1;
          if ((state == S_PLAY) && (state_nx == S_GAP)) begin
            tcnt <= 9'(GAP_T);
            pre  <= '0;
          end
        end
        S_NEXT: begin
          if (state_nx == S_LOAD) begin
            step_idx <= last ? '0 : step_idx + AW'(1);
          end else if (state_nx == S_IDLE) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
      // abort overrides any completion bookkeeping from the case above
      if ((state != S_IDLE) && stop) begin
        busy     <= 1'b0;
        done     <= 1'b0;
        step_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with DEPTH=8, TICK_DIV=1, GAP_T=2.
// Cycle cN is observed 1 time unit after the Nth rising edge following the start strobe.
module tb_tone_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int LW    = 4;

  logic          clock = 1'b0;
  logic          k_tr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic [LW-1:0] len;
  logic          loop;
  logic          stop;
  logic [7:0]    key_code;
  logic [AW-1:0] step_idx;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  tone_sequencer #(.DEPTH(DEPTH), .TICK_DIV(1), .GAP_T(2), .KEY_REL(8'hF0)) dut (
    .clock(clock), .k_tr(k_tr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .loop(loop), .stop(stop),
    .key_code(key_code), .step_idx(step_idx), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic at(input int n);
    while (cyc < n) go();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    go();
    wr_en = 1'b0;
  endtask

  task automatic play(input logic [LW-1:0] l, input logic lp);
    start = 1'b1; len = l; loop = lp;
    cyc = 0;
    go();
    start = 1'b0;
  endtask

  initial begin
    k_tr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; len = '0; loop = 1'b0; stop = 1'b0;

    // reset state
    go(); go();
    chk("rst_key", key_code, 8'hF0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", step_idx, 0);
    k_tr = 1'b1;
    go();

    // cleared entry 0 is skipped: LOAD, NEXT, done
    play(4'd1, 1'b0);
    chk("skip_c1_busy", busy, 1);
    at(2);
    chk("skip_c2_key", key_code, 8'hF0);
    chk("skip_c2_busy", busy, 1);
    at(3);
    chk("skip_c3_done", done, 1);
    chk("skip_c3_busy", busy, 0);

    // single note F5: 16 ticks of 42, 3 cycles release, done at c21
    wr(3'd0, 8'hF5);
    play(4'd1, 1'b0);
    chk("n1_c1_busy", busy, 1);
    chk("n1_c1_key", key_code, 8'hF0);
    at(2);  chk("n1_c2_key", key_code, 8'h42);
    at(17); chk("n1_c17_key", key_code, 8'h42);
    at(18); chk("n1_c18_key", key_code, 8'hF0);
    at(20); chk("n1_c20_key", key_code, 8'hF0);
    chk("n1_c20_done", done, 0);
    chk("n1_c20_busy", busy, 1);
    at(21); chk("n1_c21_done", done, 1);
    chk("n1_c21_busy", busy, 0);
    at(22); chk("n1_c22_done", done, 0);

    // {00, 82}: skipped step then note 34 for 32 cycles
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h82);
    play(4'd2, 1'b0);
    at(2);  chk("s3_c2_key", key_code, 8'hF0);
    at(3);  chk("s3_c3_idx", step_idx, 1);
    at(4);  chk("s3_c4_key", key_code, 8'h34);
    at(35); chk("s3_c35_key", key_code, 8'h34);
    at(36); chk("s3_c36_key", key_code, 8'hF0);
    at(39); chk("s3_c39_done", done, 1);

    // loop {F1, F7} with stop mid-note
    wr(3'd0, 8'hF1);
    wr(3'd1, 8'hF7);
    play(4'd2, 1'b1);
    at(2);  chk("lp_c2_key", key_code, 8'h2B);
    at(22); chk("lp_c22_key", key_code, 8'h4C);
    at(40); chk("lp_c40_busy", busy, 1);
    at(42); chk("lp_c42_key", key_code, 8'h2B);
    chk("lp_c42_idx", step_idx, 0);
    at(62); chk("lp_c62_key", key_code, 8'h4C);
    at(65); stop = 1'b1;
    go();
    stop = 1'b0;
    chk("stop_key", key_code, 8'hF0);
    chk("stop_busy", busy, 0);
    chk("stop_idx", step_idx, 0);
    chk("stop_done", done, 0);
    go();
    chk("stop_done2", done, 0);

    // start while busy with a new len is ignored
    wr(3'd0, 8'hF5);
    play(4'd1, 1'b0);
    at(5);
    start = 1'b1; len = 4'd2;
    go();
    start = 1'b0;
    at(20); chk("rb_c20_idx", step_idx, 0);
    chk("rb_c20_busy", busy, 1);
    at(21); chk("rb_c21_done", done, 1);
    at(22); chk("rb_c22_busy", busy, 0);

    // len==0 and start with stop are both ignored
    start = 1'b1; len = 4'd0;
    go();
    start = 1'b0;
    go();
    chk("len0_busy", busy, 0);
    start = 1'b1; stop = 1'b1; len = 4'd1;
    go();
    start = 1'b0; stop = 1'b0;
    go();
    chk("ststop_busy", busy, 0);

    // reset during PLAY clears outputs and the table
    play(4'd1, 1'b0);
    at(5); chk("rp_c5_key", key_code, 8'h42);
    k_tr = 1'b0;
    go();
    chk("rp_key", key_code, 8'hF0);
    chk("rp_busy", busy, 0);
    chk("rp_idx", step_idx, 0);
    k_tr = 1'b1;
    play(4'd1, 1'b0);
    at(2); chk("rp_cleared_key", key_code, 8'hF0);
    at(3); chk("rp_cleared_done", done, 1);

    // oversized len clamps to DEPTH; all entries skipped, 2 cycles each
    play(4'd13, 1'b0);
    at(9);  chk("cl_c9_idx", step_idx, 4);
    at(16); chk("cl_c16_idx", step_idx, 7);
    chk("cl_c16_busy", busy, 1);
    at(17); chk("cl_c17_done", done, 1);
    chk("cl_c17_busy", busy, 0);

    // rewrite entry 3 while it plays in loop mode: heard on next pass only
    wr(3'd3, 8'hF1);
    play(4'd4, 1'b1);
    at(8); chk("wp_c8_key", key_code, 8'h2B);
    chk("wp_c8_idx", step_idx, 3);
    at(10);
    wr(3'd3, 8'hF7);
    chk("wp_c11_key", key_code, 8'h2B);
    at(23); chk("wp_c23_key", key_code, 8'h2B);
    at(24); chk("wp_c24_key", key_code, 8'hF0);
    at(34); chk("wp_c34_key", key_code, 8'h4C);
    chk("wp_c34_idx", step_idx, 3);
    stop = 1'b1;
    go();
    stop = 1'b0;
    chk("wp_stop_busy", busy, 0);

    // long note 3A: 96 cycles of 52
    wr(3'd0, 8'h3A);
    play(4'd1, 1'b0);
    at(2);  chk("ln_c2_key", key_code, 8'h52);
    at(97); chk("ln_c97_key", key_code, 8'h52);
    at(98); chk("ln_c98_key", key_code, 8'hF0);
    at(101); chk("ln_c101_done", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
